register_file_mp: RTL and testbench

Parametrised multi-port MIPS general-purpose register file with HI/LO pair, same-cycle write-to-read bypass and a per-register pending-write scoreboard. It replaces the single-write, two-read register file in the decode stage, so the core can retire two results per cycle and interlock on long-latency producers (loads, multiply/divide). All reads are combinational; all state updates occur on the rising edge of `clk`.

---
 rtl/register_file_mp.sv | 118 +++++++++++
 tb/tb_register_file_mp.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Multi-port MIPS general-purpose register file with a HI/LO pair,
// same-cycle write-to-read forwarding and a per-register pending-write scoreboard.
module register_file_mp #(
  parameter int unsigned  NUM_READ  = 2,
  parameter int unsigned  NUM_WRITE = 2,
  parameter int unsigned  WIDTH     = 32,
  parameter int unsigned  DEPTH     = 32,
  parameter bit           BYPASS    = 1'b1,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_READ*AW-1:0]     readReg,
  output logic [NUM_READ*WIDTH-1:0]  readData,
  output logic [NUM_READ-1:0]        readBusy,
  input  logic [NUM_WRITE-1:0]       writeEn,
  input  logic [NUM_WRITE*AW-1:0]    writeReg,
  input  logic [NUM_WRITE*WIDTH-1:0] writeData,
  input  logic                       writeLoHi,
  input  logic [WIDTH-1:0]           writeDataLo,
  input  logic [WIDTH-1:0]           writeDataHi,
  output logic [WIDTH-1:0]           hi,
  output logic [WIDTH-1:0]           lo,
  input  logic                       markBusy,
  input  logic [AW-1:0]              markReg
);

  logic [WIDTH-1:0] regArray [DEPTH];
  logic [DEPTH-1:0] busyQ;
  logic [DEPTH-1:0] busyD;
  logic [WIDTH-1:0] hiQ;
  logic [WIDTH-1:0] loQ;

  // r0 and indices past the end of a non-power-of-two array are never real storage.
  function automatic logic isLive(logic [AW-1:0] addr);
    return (32'(addr) < DEPTH) && (addr != '0);
  endfunction

  // Register array: ports applied in index order so the youngest port wins a conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        regArray[r] <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < NUM_WRITE; j++) begin
        if (writeEn[j] && isLive(writeReg[j*AW +: AW])) begin
          regArray[writeReg[j*AW +: AW]] <= writeData[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Scoreboard next state: writes retire producers, then a new mark takes precedence.
  always_comb begin
    busyD = busyQ;
    for (int unsigned j = 0; j < NUM_WRITE; j++) begin
      if (writeEn[j] && isLive(writeReg[j*AW +: AW])) begin
        busyD[writeReg[j*AW +: AW]] = 1'b0;
      end
    end
    if (markBusy && isLive(markReg)) begin
      busyD[markReg] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busyQ <= '0;
    end else begin
      busyQ <= busyD;
    end
  end

  // HI/LO pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      hiQ <= '0;
      loQ <= '0;
    end else if (writeLoHi) begin
      hiQ <= writeDataHi;
      loQ <= writeDataLo;
    end
  end

  assign hi = (BYPASS && writeLoHi) ? writeDataHi : hiQ;
  assign lo = (BYPASS && writeLoHi) ? writeDataLo : loQ;

  for (genvar i = 0; i < NUM_READ; i++) begin : gRead
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic             fwdHit;
    logic             fwdMark;

    assign addr = readReg[i*AW +: AW];

    // Read mux with optional forwarding; later ports override earlier ones.
    always_comb begin
      data   = isLive(addr) ? regArray[addr] : '0;
      fwdHit = 1'b0;
      if (BYPASS) begin
        for (int unsigned j = 0; j < NUM_WRITE; j++) begin
          if (writeEn[j] && isLive(addr) && (writeReg[j*AW +: AW] == addr)) begin
            data   = writeData[j*WIDTH +: WIDTH];
            fwdHit = 1'b1;
          end
        end
      end
    end

    assign fwdMark = markBusy && (markReg == addr);
    assign readData[i*WIDTH +: WIDTH] = data;
    // A forwarded result is no longer pending unless a new producer claims it this cycle.
    assign readBusy[i] = isLive(addr) && busyQ[addr] && !(fwdHit && !fwdMark);
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: a forwarding and a non-forwarding
// instance share stimulus; directed table, HI/LO/reset sequence, random phase.
module tb_register_file_mp;

  localparam int unsigned NR = 2;
  localparam int unsigned NW = 2;
  localparam int unsigned W  = 32;
  localparam int unsigned D  = 32;
  localparam int unsigned AW = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] readReg;
  logic [NR*W-1:0]  readDataB, readDataN;
  logic [NR-1:0]    readBusyB, readBusyN;
  logic [NW-1:0]    writeEn;
  logic [NW*AW-1:0] writeReg;
  logic [NW*W-1:0]  writeData;
  logic             writeLoHi;
  logic [W-1:0]     writeDataLo, writeDataHi;
  logic [W-1:0]     hiB, loB, hiN, loN;
  logic             markBusy;
  logic [AW-1:0]    markReg;

  always #5 clk = ~clk;

  register_file_mp #(.NUM_READ(NR), .NUM_WRITE(NW), .WIDTH(W), .DEPTH(D), .BYPASS(1'b1)) dutB (
    .clk(clk), .rst(rst), .readReg(readReg), .readData(readDataB), .readBusy(readBusyB),
    .writeEn(writeEn), .writeReg(writeReg), .writeData(writeData), .writeLoHi(writeLoHi),
    .writeDataLo(writeDataLo), .writeDataHi(writeDataHi), .hi(hiB), .lo(loB),
    .markBusy(markBusy), .markReg(markReg)
  );

  register_file_mp #(.NUM_READ(NR), .NUM_WRITE(NW), .WIDTH(W), .DEPTH(D), .BYPASS(1'b0)) dutN (
    .clk(clk), .rst(rst), .readReg(readReg), .readData(readDataN), .readBusy(readBusyN),
    .writeEn(writeEn), .writeReg(writeReg), .writeData(writeData), .writeLoHi(writeLoHi),
    .writeDataLo(writeDataLo), .writeDataHi(writeDataHi), .hi(hiN), .lo(loN),
    .markBusy(markBusy), .markReg(markReg)
  );

  // Reference state.
  logic [W-1:0] mRegs [D];
  logic [D-1:0] mBusy;
  logic [W-1:0] mHi, mLo;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wr0;
    logic [31:0] wd0;
    logic [4:0]  wr1;
    logic [31:0] wd1;
    logic        mk;
    logic [4:0]  mr;
    logic [4:0]  rr0;
    logic [4:0]  rr1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic [31:0] n0;
    logic [31:0] n1;
    logic [1:0]  nb;
  } tableRow;

  tableRow vecs[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    writeEn     = '0;
    writeReg    = '0;
    writeData   = '0;
    writeLoHi   = 1'b0;
    writeDataLo = '0;
    writeDataHi = '0;
    markBusy    = 1'b0;
    markReg     = '0;
  endtask

  // Clock edge plus the architectural effect of the inputs presented during that cycle.
  task automatic tick();
    logic [AW-1:0] r;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < int'(D); k++) mRegs[k] = '0;
      mBusy = '0;
      mHi   = '0;
      mLo   = '0;
    end else begin
      for (int j = 0; j < int'(NW); j++) begin
        r = writeReg[j*AW +: AW];
        if (writeEn[j] && r != 0) begin
          mRegs[r] = writeData[j*W +: W];
          mBusy[r] = 1'b0;
        end
      end
      if (markBusy && markReg != 0) mBusy[markReg] = 1'b1;
      if (writeLoHi) begin
        mHi = writeDataHi;
        mLo = writeDataLo;
      end
    end
    #1;
  endtask

  function automatic logic [W-1:0] expData(bit byp, int i);
    logic [AW-1:0] r = readReg[i*AW +: AW];
    if (r == 0) return '0;
    if (byp) begin
      for (int j = int'(NW) - 1; j >= 0; j--) begin
        if (writeEn[j] && writeReg[j*AW +: AW] == r) return writeData[j*W +: W];
      end
    end
    return mRegs[r];
  endfunction

  function automatic logic expBusy(bit byp, int i);
    logic [AW-1:0] r = readReg[i*AW +: AW];
    logic written = 1'b0;
    if (r == 0) return 1'b0;
    for (int j = 0; j < int'(NW); j++) begin
      if (writeEn[j] && writeReg[j*AW +: AW] == r) written = 1'b1;
    end
    if (byp && written && !(markBusy && markReg == r)) return 1'b0;
    return mBusy[r];
  endfunction

  task automatic checkModel(string tag);
    for (int i = 0; i < int'(NR); i++) begin
      check($sformatf("%s rdata%0d byp1", tag, i), readDataB[i*W +: W], expData(1'b1, i));
      check($sformatf("%s rdata%0d byp0", tag, i), readDataN[i*W +: W], expData(1'b0, i));
      check($sformatf("%s busy%0d byp1", tag, i), 32'(readBusyB[i]), 32'(expBusy(1'b1, i)));
      check($sformatf("%s busy%0d byp0", tag, i), 32'(readBusyN[i]), 32'(expBusy(1'b0, i)));
    end
    check({tag, " hi byp1"}, hiB, writeLoHi ? writeDataHi : mHi);
    check({tag, " lo byp1"}, loB, writeLoHi ? writeDataLo : mLo);
    check({tag, " hi byp0"}, hiN, mHi);
    check({tag, " lo byp0"}, loN, mLo);
  endtask

  initial begin
    // we, wr0, wd0, wr1, wd1, mk, mr, rr0, rr1, e0, e1, eb, n0, n1, nb
    vecs.push_back(tableRow'{2'b01, 5'd10, 32'hdead0000, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd0,
                             32'hdead0000, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00});
    vecs.push_back(tableRow'{2'b11, 5'd10, 32'h0000beef, 5'd0, 32'h20200523, 1'b0, 5'd0, 5'd10,
                             5'd0, 32'hbeef, 32'h0, 2'b00, 32'hdead0000, 32'h0, 2'b00});
    vecs.push_back(tableRow'{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd0,
                             32'hbeef, 32'h0, 2'b00, 32'hbeef, 32'h0, 2'b00});
    vecs.push_back(tableRow'{2'b01, 5'd5, 32'h12345678, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5,
                             32'h0, 32'h12345678, 2'b00, 32'h0, 32'h0, 2'b00});
    vecs.push_back(tableRow'{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5,
                             32'h0, 32'h12345678, 2'b00, 32'h0, 32'h12345678, 2'b00});
    vecs.push_back(tableRow'{2'b11, 5'd7, 32'h1111, 5'd7, 32'h2222, 1'b0, 5'd0, 5'd7, 5'd7,
                             32'h2222, 32'h2222, 2'b00, 32'h0, 32'h0, 2'b00});
    vecs.push_back(tableRow'{2'b11, 5'd3, 32'haaaa, 5'd4, 32'hbbbb, 1'b0, 5'd0, 5'd3, 5'd4,
                             32'haaaa, 32'hbbbb, 2'b00, 32'h0, 32'h0, 2'b00});
    vecs.push_back(tableRow'{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd3,
                             32'h2222, 32'haaaa, 2'b00, 32'h2222, 32'haaaa, 2'b00});
    vecs.push_back(tableRow'{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd7,
                             32'hbbbb, 32'h2222, 2'b00, 32'hbbbb, 32'h2222, 2'b00});
    vecs.push_back(tableRow'{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9,
                             32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00});
    vecs.push_back(tableRow'{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9,
                             32'h0, 32'h0, 2'b11, 32'h0, 32'h0, 2'b11});
    vecs.push_back(tableRow'{2'b01, 5'd9, 32'h55, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9,
                             32'h55, 32'h55, 2'b00, 32'h0, 32'h0, 2'b11});
    vecs.push_back(tableRow'{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9,
                             32'h55, 32'h55, 2'b00, 32'h55, 32'h55, 2'b00});
    vecs.push_back(tableRow'{2'b10, 5'd0, 32'h0, 5'd9, 32'h66, 1'b1, 5'd9, 5'd9, 5'd9,
                             32'h66, 32'h66, 2'b00, 32'h55, 32'h55, 2'b00});
    vecs.push_back(tableRow'{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9,
                             32'h66, 32'h66, 2'b11, 32'h66, 32'h66, 2'b11});
    vecs.push_back(tableRow'{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd9,
                             32'h0, 32'h66, 2'b10, 32'h0, 32'h66, 2'b10});
    vecs.push_back(tableRow'{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9,
                             32'h0, 32'h66, 2'b10, 32'h0, 32'h66, 2'b10});

    // Reset.
    rst     = 1'b1;
    readReg = '0;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset: every register reads zero and not busy.
    for (int r = 0; r < 32; r++) begin
      readReg = {5'(31 - r), 5'(r)};
      #2;
      check($sformatf("reset rdata0 r%0d", r), readDataB[31:0], 32'h0);
      check($sformatf("reset rdata1 r%0d", 31 - r), readDataB[63:32], 32'h0);
      check($sformatf("reset busy r%0d", r), 32'(readBusyB), 32'h0);
      #1;
    end
    check("reset hi", hiB, 32'h0);
    check("reset lo", loB, 32'h0);

    // Directed table.
    foreach (vecs[k]) begin
      writeEn   = vecs[k].we;
      writeReg  = {vecs[k].wr1, vecs[k].wr0};
      writeData = {vecs[k].wd1, vecs[k].wd0};
      markBusy  = vecs[k].mk;
      markReg   = vecs[k].mr;
      readReg   = {vecs[k].rr1, vecs[k].rr0};
      #2;
      check($sformatf("vec%0d rdata0 byp1", k), readDataB[31:0], vecs[k].e0);
      check($sformatf("vec%0d rdata1 byp1", k), readDataB[63:32], vecs[k].e1);
      check($sformatf("vec%0d busy byp1", k), 32'(readBusyB), 32'(vecs[k].eb));
      check($sformatf("vec%0d rdata0 byp0", k), readDataN[31:0], vecs[k].n0);
      check($sformatf("vec%0d rdata1 byp0", k), readDataN[63:32], vecs[k].n1);
      check($sformatf("vec%0d busy byp0", k), 32'(readBusyN), 32'(vecs[k].nb));
      tick();
    end
    idle();

    // HI/LO load, forwarded only by the bypassing build; also mark r10 busy.
    writeLoHi   = 1'b1;
    writeDataLo = 32'hbeefbeef;
    writeDataHi = 32'hdeaddead;
    markBusy    = 1'b1;
    markReg     = 5'd10;
    readReg     = {5'd9, 5'd10};
    #2;
    check("hilo hi byp1", hiB, 32'hdeaddead);
    check("hilo lo byp1", loB, 32'hbeefbeef);
    check("hilo hi byp0", hiN, 32'h0);
    check("hilo lo byp0", loN, 32'h0);
    tick();
    idle();
    #2;
    check("hilo hi after", hiN, 32'hdeaddead);
    check("hilo lo after", loN, 32'hbeefbeef);
    check("r10 busy after mark", 32'(readBusyB), 32'h3);

    // Reset with r10/r9 busy, writes and a mark in flight: nothing survives.
    rst       = 1'b1;
    writeEn   = 2'b11;
    writeReg  = {5'd12, 5'd10};
    writeData = {32'h88, 32'h77};
    markBusy  = 1'b1;
    markReg   = 5'd11;
    tick();
    rst = 1'b0;
    idle();
    readReg = {5'd12, 5'd10};
    #2;
    check("rst r10 data", readDataB[31:0], 32'h0);
    check("rst r12 data", readDataB[63:32], 32'h0);
    check("rst r10 busy", 32'(readBusyB), 32'h0);
    check("rst hi", hiB, 32'h0);
    check("rst lo", loN, 32'h0);
    readReg = {5'd9, 5'd11};
    #1;
    check("rst r11/r9 busy", 32'(readBusyB), 32'h0);
    tick();

    // Random phase against the reference model; small address range forces conflicts.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int j = 0; j < int'(NW); j++) begin
        writeEn[j]          = ($urandom_range(0, 2) != 0);
        writeReg[j*AW +: AW] = 5'($urandom_range(0, 7));
        writeData[j*W +: W]  = $urandom;
      end
      for (int i = 0; i < int'(NR); i++) readReg[i*AW +: AW] = 5'($urandom_range(0, 7));
      markBusy    = ($urandom_range(0, 2) == 0);
      markReg     = 5'($urandom_range(0, 7));
      writeLoHi   = ($urandom_range(0, 3) == 0);
      writeDataLo = $urandom;
      writeDataHi = $urandom;
      #2;
      checkModel($sformatf("rand%0d", n));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
